// File: rtl/icache_direct_mapped.sv
// icache_direct_mapped: read-only direct-mapped instruction cache with same-cycle hits and 128-bit line fill on miss
module icache_direct_mapped #(
  parameter int NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic [1:0]   mem_byte_enable,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 12 - IDX_W;
  typedef enum logic {IDLE, FETCH} state_t;
  state_t state, state_nxt;
  logic [NUM_SETS-1:0] valid;
  logic [TAG_W-1:0] tags [NUM_SETS];
  logic [127:0] lines [NUM_SETS];
  logic [TAG_W-1:0] req_tag, fetch_tag;
  logic [IDX_W-1:0] req_idx, fetch_idx;
  logic [2:0] req_word;
  logic hit, miss, fill, unused_ok;
  assign req_idx = mem_address[4 +: IDX_W];
  assign req_tag = mem_address[15 -: TAG_W];
  assign req_word = mem_address[3:1];
  assign unused_ok = ^{mem_byte_enable, mem_address[0]};
  assign hit = state == IDLE && mem_read && valid[req_idx] && tags[req_idx] == req_tag;
  assign miss = state == IDLE && mem_read && !hit;
  assign fill = state == FETCH && pmem_resp;
  // next state and all outputs; responses are zeroed when not asserted
  always_comb begin
    state_nxt = fill ? IDLE : miss ? FETCH : state;
    mem_resp = hit;
    mem_rdata = hit ? lines[req_idx][{req_word, 4'b0000} +: 16] : 16'h0000;
    pmem_read = state == FETCH;
    pmem_address = pmem_read ? {fetch_tag, fetch_idx, 4'b0000} : 16'h0000;
  end
  // state, valid bits and latched miss address; reset mid-fetch drops pmem_read at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      valid <= '0;
      fetch_tag <= '0;
      fetch_idx <= '0;
    end else begin
      state <= state_nxt;
      if (miss) begin
        fetch_tag <= req_tag;
        fetch_idx <= req_idx;
      end
      if (fill) valid[fetch_idx] <= 1'b1;
    end
  end
  // tag and line storage carry no reset; validity alone gates their use
  always_ff @(posedge clk) begin
    if (fill) begin
      tags[fetch_idx] <= fetch_tag;
      lines[fetch_idx] <= pmem_rdata;
    end
  end
endmodule
